// File: rtl/reg_op_seq_if.sv
//==============================================================================
// Module : reg_op_seq_if
// Brief  : Command handshake plus register-file port bundle for reg_op_seq.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface reg_op_seq_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic [AW-1:0] cmd_dst;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] radda;
    logic [AW-1:0] raddb;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic          w;
    logic [AW-1:0] wadd;
    logic [DW-1:0] wdata;
    logic          done;
    logic [DW-1:0] result;
    logic          carry;
    logic          zero;

    // The sequencer is the slave of the command issuer.
    modport slave (
        input  cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_imm, ra, rb,
        output cmd_ready, radda, raddb, w, wadd, wdata, done, result, carry, zero
    );

    modport master (
        output cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_imm, ra, rb,
        input  cmd_ready, radda, raddb, w, wadd, wdata, done, result, carry, zero
    );
endinterface

`default_nettype wire

// File: rtl/reg_op_seq.sv
//==============================================================================
// Module : reg_op_seq
// Brief  : Register-to-register command sequencer with ALU and bulk clear.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_op_seq #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    reg_op_seq_if.slave  bus
);

    localparam logic [2:0] c_OP_MOV = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_XOR = 3'b101;
    localparam logic [2:0] c_OP_LDI = 3'b110;
    localparam logic [2:0] c_OP_CLR = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic [AW-1:0] r_srca;
    logic [AW-1:0] r_srcb;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic [DW-1:0] r_result;
    logic          r_carry;
    logic          r_zero;
    logic [AW-1:0] r_clr_cnt;

    logic          w_accept;
    logic          w_clr_last;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW-1:0] w_alu;
    logic          w_alu_carry;

    assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
    assign w_clr_last = &r_clr_cnt;
    assign w_sum      = {1'b0, r_opa} + {1'b0, r_opb};
    // Bit DW of the zero-extended difference is the unsigned borrow (A < B).
    assign w_diff     = {1'b0, r_opa} - {1'b0, r_opb};

    always_comb begin
        w_alu       = '0;
        w_alu_carry = 1'b0;
        case (r_op)
            c_OP_MOV: w_alu = r_opa;
            c_OP_ADD: begin
                w_alu       = w_sum[DW-1:0];
                w_alu_carry = w_sum[DW];
            end
            c_OP_SUB: begin
                w_alu       = w_diff[DW-1:0];
                w_alu_carry = w_diff[DW];
            end
            c_OP_AND: w_alu = r_opa & r_opb;
            c_OP_OR:  w_alu = r_opa | r_opb;
            c_OP_XOR: w_alu = r_opa ^ r_opb;
            c_OP_LDI: w_alu = r_imm;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (bus.cmd_op == c_OP_CLR) ? S_CLR : S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            S_CLR:   if (w_clr_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_srca    <= '0;
            r_srcb    <= '0;
            r_dst     <= '0;
            r_imm     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= bus.cmd_op;
                r_srca    <= bus.cmd_srca;
                r_srcb    <= bus.cmd_srcb;
                r_dst     <= bus.cmd_dst;
                r_imm     <= bus.cmd_imm;
                r_clr_cnt <= '0;
                if (bus.cmd_op == c_OP_CLR) begin
                    r_result <= '0;
                    r_carry  <= 1'b0;
                    r_zero   <= 1'b1;
                end
            end
            if (r_state == S_READ) begin
                r_opa <= bus.ra;
                r_opb <= bus.rb;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu;
                r_carry  <= w_alu_carry;
                r_zero   <= (w_alu == '0);
            end
            if (r_state == S_CLR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Write-side outputs are decoded from state so reset drops w at once.
    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.w         = 1'b0;
        bus.wadd      = '0;
        bus.wdata     = '0;
        bus.done      = 1'b0;
        case (r_state)
            S_WRITE: begin
                bus.w     = 1'b1;
                bus.wadd  = r_dst;
                bus.wdata = r_result;
                bus.done  = 1'b1;
            end
            S_CLR: begin
                bus.w    = 1'b1;
                bus.wadd = r_clr_cnt;
                bus.done = w_clr_last;
            end
            default: ;
        endcase
    end

    assign bus.radda  = r_srca;
    assign bus.raddb  = r_srcb;
    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_reg_op_seq.sv
//==============================================================================
// Module : tb_reg_op_seq
// Brief  : Directed bench for reg_op_seq attached to an 8 x 8-bit register file.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_op_seq;

    localparam logic [2:0] c_MOV = 3'b000;
    localparam logic [2:0] c_ADD = 3'b001;
    localparam logic [2:0] c_SUB = 3'b010;
    localparam logic [2:0] c_AND = 3'b011;
    localparam logic [2:0] c_OR  = 3'b100;
    localparam logic [2:0] c_XOR = 3'b101;
    localparam logic [2:0] c_LDI = 3'b110;
    localparam logic [2:0] c_CLR = 3'b111;

    logic       clk;
    logic       rst_n;
    logic       r_rf_clear;
    logic [7:0] rf [8];
    int         n_cmp;
    int         n_err;

    reg_op_seq_if #(.DW(8), .AW(3)) bus ();

    reg_op_seq #(.DW(8), .AW(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ra = rf[bus.radda];
    assign bus.rb = rf[bus.raddb];

    always @(posedge clk) begin
        if (r_rf_clear) begin
            for (int k = 0; k < 8; k++) rf[k] <= 8'h00;
        end else if (bus.w) begin
            rf[bus.wadd] <= bus.wdata;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Issues one register command from a negedge and ends at the cycle-4 negedge.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input logic [7:0] imm,
                           input logic [7:0] exp_res, input logic exp_c, input logic exp_z);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_srca  = a;
        bus.cmd_srcb  = b;
        bus.cmd_dst   = d;
        bus.cmd_imm   = imm;
        chk("c0_ready", {7'd0, bus.cmd_ready}, 8'h01);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("c1_ready", {7'd0, bus.cmd_ready}, 8'h00);
        chk("c1_w", {7'd0, bus.w}, 8'h00);
        chk("c1_radda", {5'd0, bus.radda}, {5'd0, a});
        chk("c1_raddb", {5'd0, bus.raddb}, {5'd0, b});
        @(negedge clk);
        chk("c2_done", {7'd0, bus.done}, 8'h00);
        chk("c2_w", {7'd0, bus.w}, 8'h00);
        @(negedge clk);
        chk("c3_done", {7'd0, bus.done}, 8'h01);
        chk("c3_w", {7'd0, bus.w}, 8'h01);
        chk("c3_wadd", {5'd0, bus.wadd}, {5'd0, d});
        chk("c3_wdata", bus.wdata, exp_res);
        chk("c3_result", bus.result, exp_res);
        chk("c3_carry", {7'd0, bus.carry}, {7'd0, exp_c});
        chk("c3_zero", {7'd0, bus.zero}, {7'd0, exp_z});
        @(negedge clk);
        chk("c4_ready", {7'd0, bus.cmd_ready}, 8'h01);
        chk("c4_w", {7'd0, bus.w}, 8'h00);
        chk("c4_rf", rf[d], exp_res);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) begin
            run_cmd(c_LDI, 3'd0, 3'd0, 3'(i), 8'(8'h11 * (i + 1)), 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        r_rf_clear = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_srca  = 3'd0;
        bus.cmd_srcb  = 3'd0;
        bus.cmd_dst   = 3'd0;
        bus.cmd_imm   = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_ready", {7'd0, bus.cmd_ready}, 8'h01);
        chk("rst_w", {7'd0, bus.w}, 8'h00);
        chk("rst_done", {7'd0, bus.done}, 8'h00);
        chk("rst_carry", {7'd0, bus.carry}, 8'h00);
        chk("rst_zero", {7'd0, bus.zero}, 8'h00);
        chk("rst_wadd", {5'd0, bus.wadd}, 8'h00);
        chk("rst_wdata", bus.wdata, 8'h00);
        chk("rst_radda", {5'd0, bus.radda}, 8'h00);
        chk("rst_raddb", {5'd0, bus.raddb}, 8'h00);
        chk("rst_result", bus.result, 8'h00);

        r_rf_clear = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // LDI chain
        run_cmd(c_LDI, 3'd0, 3'd0, 3'd1, 8'h7F, 8'h7F, 1'b0, 1'b0);
        run_cmd(c_LDI, 3'd0, 3'd0, 3'd2, 8'h01, 8'h01, 1'b0, 1'b0);
        run_cmd(c_ADD, 3'd1, 3'd2, 3'd3, 8'h00, 8'h80, 1'b0, 1'b0);

        // Overflow and borrow
        run_cmd(c_LDI, 3'd0, 3'd0, 3'd1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_cmd(c_LDI, 3'd0, 3'd0, 3'd2, 8'h01, 8'h01, 1'b0, 1'b0);
        run_cmd(c_ADD, 3'd1, 3'd2, 3'd4, 8'h00, 8'h00, 1'b1, 1'b1);
        run_cmd(c_SUB, 3'd2, 3'd1, 3'd5, 8'h00, 8'h02, 1'b1, 1'b0);
        run_cmd(c_SUB, 3'd1, 3'd2, 3'd6, 8'h00, 8'hFE, 1'b0, 1'b0);

        // Logic ops with shared operands
        run_cmd(c_LDI, 3'd0, 3'd0, 3'd1, 8'hA5, 8'hA5, 1'b0, 1'b0);
        run_cmd(c_LDI, 3'd0, 3'd0, 3'd2, 8'h0F, 8'h0F, 1'b0, 1'b0);
        run_cmd(c_AND, 3'd1, 3'd2, 3'd1, 8'h00, 8'h05, 1'b0, 1'b0);
        run_cmd(c_XOR, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 1'b0, 1'b1);
        run_cmd(c_OR,  3'd2, 3'd2, 3'd7, 8'h00, 8'h0F, 1'b0, 1'b0);
        run_cmd(c_MOV, 3'd7, 3'd3, 3'd0, 8'h00, 8'h0F, 1'b0, 1'b0);

        // CLRALL over a filled file
        fill_all();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = c_CLR;
        chk("clr_c0_ready", {7'd0, bus.cmd_ready}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (i == 0) begin
                chk("clr_result", bus.result, 8'h00);
                chk("clr_zero", {7'd0, bus.zero}, 8'h01);
                chk("clr_carry", {7'd0, bus.carry}, 8'h00);
            end
            chk("clr_w", {7'd0, bus.w}, 8'h01);
            chk("clr_wadd", {5'd0, bus.wadd}, 8'(i));
            chk("clr_wdata", bus.wdata, 8'h00);
            chk("clr_done", {7'd0, bus.done}, (i == 7) ? 8'h01 : 8'h00);
            chk("clr_ready", {7'd0, bus.cmd_ready}, 8'h00);
        end
        @(negedge clk);
        chk("clr_c9_w", {7'd0, bus.w}, 8'h00);
        chk("clr_c9_done", {7'd0, bus.done}, 8'h00);
        chk("clr_c9_ready", {7'd0, bus.cmd_ready}, 8'h01);
        for (int i = 0; i < 8; i++) chk("clr_rf", rf[i], 8'h00);

        // cmd_valid held with changing fields while busy
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = c_LDI;
        bus.cmd_dst   = 3'd2;
        bus.cmd_imm   = 8'h3C;
        chk("hs_c0_ready", {7'd0, bus.cmd_ready}, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.cmd_op   = c_ADD;
            bus.cmd_dst  = 3'd5;
            bus.cmd_imm  = 8'(8'h90 + i);
            bus.cmd_srca = 3'(i);
            chk("hs_ready", {7'd0, bus.cmd_ready}, 8'h00);
        end
        chk("hs_c3_wadd", {5'd0, bus.wadd}, 8'h02);
        chk("hs_c3_wdata", bus.wdata, 8'h3C);
        chk("hs_c3_done", {7'd0, bus.done}, 8'h01);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("hs_c4_ready", {7'd0, bus.cmd_ready}, 8'h01);
        @(negedge clk);
        chk("hs_c5_w", {7'd0, bus.w}, 8'h00);
        chk("hs_rf2", rf[2], 8'h3C);
        chk("hs_rf5", rf[5], 8'h00);

        // Reset in the middle of CLRALL
        fill_all();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = c_CLR;
        repeat (4) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        chk("mid_wadd", {5'd0, bus.wadd}, 8'h03);
        rst_n = 1'b0;
        #1;
        chk("mid_w", {7'd0, bus.w}, 8'h00);
        chk("mid_done", {7'd0, bus.done}, 8'h00);
        chk("mid_wadd_rst", {5'd0, bus.wadd}, 8'h00);
        chk("mid_result", bus.result, 8'h00);
        chk("mid_zero", {7'd0, bus.zero}, 8'h00);
        chk("mid_carry", {7'd0, bus.carry}, 8'h00);
        chk("mid_ready", {7'd0, bus.cmd_ready}, 8'h01);
        chk("mid_radda", {5'd0, bus.radda}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("mid_rf_lo", rf[i], 8'h00);
        for (int i = 4; i < 8; i++) chk("mid_rf_hi", rf[i], 8'(8'h11 * (i + 1)));
        run_cmd(c_ADD, 3'd4, 3'd5, 3'd0, 8'h00, 8'hBB, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
